// File: rtl/fsm_control_multi_if.sv
// rtl/fsm_control_multi_if.sv - FIFO-side configuration and status bundle for fsm_control_multi
interface fsm_control_multi_if #(
    parameter int NUM_FIFOS = 4,
    parameter int UMBRAL_W  = 8
);
    logic                 init;
    logic [UMBRAL_W-1:0]  umbral_alto;
    logic [UMBRAL_W-1:0]  umbral_bajo;
    logic [NUM_FIFOS-1:0] FIFO_empty;
    logic [NUM_FIFOS-1:0] FIFO_error;
    logic [UMBRAL_W-1:0]  umbral_alto_o;
    logic [UMBRAL_W-1:0]  umbral_bajo_o;
    logic                 idle;
    logic                 active;
    logic                 error;
    logic                 init_o;
    logic [1:0]           error_code;
    logic [NUM_FIFOS-1:0] error_fifo;

    modport master (
        input  init, umbral_alto, umbral_bajo, FIFO_empty, FIFO_error,
        output umbral_alto_o, umbral_bajo_o, idle, active, error, init_o,
               error_code, error_fifo
    );

    modport slave (
        output init, umbral_alto, umbral_bajo, FIFO_empty, FIFO_error,
        input  umbral_alto_o, umbral_bajo_o, idle, active, error, init_o,
               error_code, error_fifo
    );
endinterface

// File: rtl/fsm_control_multi.sv
// rtl/fsm_control_multi.sv - flow-control master FSM for NUM_FIFOS VC FIFOs
module fsm_control_multi #(
    parameter int NUM_FIFOS = 4,
    parameter int UMBRAL_W  = 8
) (
    input  logic                clk,
    input  logic                reset,
    fsm_control_multi_if.master bus
);
    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_INIT   = 3'd1,
        S_IDLE   = 3'd2,
        S_ACTIVE = 3'd3,
        S_ERROR  = 3'd4
    } state_t;

    localparam logic [1:0] CODE_NONE = 2'b00;
    localparam logic [1:0] CODE_FIFO = 2'b01;
    localparam logic [1:0] CODE_CFG  = 2'b10;

    state_t               state_q, state_d;
    logic [UMBRAL_W-1:0]  alto_q, alto_d;
    logic [UMBRAL_W-1:0]  bajo_q, bajo_d;
    logic [1:0]           code_q, code_d;
    logic [NUM_FIFOS-1:0] efifo_q, efifo_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_RESET;
            alto_q  <= '0;
            bajo_q  <= '0;
            code_q  <= CODE_NONE;
            efifo_q <= '0;
        end else begin
            state_q <= state_d;
            alto_q  <= alto_d;
            bajo_q  <= bajo_d;
            code_q  <= code_d;
            efifo_q <= efifo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        alto_d  = alto_q;
        bajo_d  = bajo_q;
        code_d  = code_q;
        efifo_d = efifo_q;
        case (state_q)
            S_RESET: state_d = S_INIT;
            S_INIT: begin
                // The validity check uses the values being latched this cycle.
                alto_d = bus.umbral_alto;
                bajo_d = bus.umbral_bajo;
                if (!bus.init) begin
                    if (bajo_d >= alto_d) begin
                        state_d = S_ERROR;
                        code_d  = CODE_CFG;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_IDLE, S_ACTIVE: begin
                if (|bus.FIFO_error) begin
                    state_d = S_ERROR;
                    code_d  = CODE_FIFO;
                    efifo_d = bus.FIFO_error;
                end else if (bus.init) begin
                    state_d = S_INIT;
                end else if (state_q == S_IDLE && !(&bus.FIFO_empty)) begin
                    state_d = S_ACTIVE;
                end else if (state_q == S_ACTIVE && (&bus.FIFO_empty)) begin
                    state_d = S_IDLE;
                end
            end
            S_ERROR: begin
                efifo_d = efifo_q | bus.FIFO_error;
                if (bus.init && bus.FIFO_error == '0) begin
                    state_d = S_INIT;
                end
            end
            default: state_d = S_RESET;
        endcase
        if (state_d == S_INIT) begin
            code_d  = CODE_NONE;
            efifo_d = '0;
        end
    end

    assign bus.umbral_alto_o = alto_q;
    assign bus.umbral_bajo_o = bajo_q;
    assign bus.idle          = (state_q == S_IDLE);
    assign bus.active        = (state_q == S_ACTIVE);
    assign bus.error         = (state_q == S_ERROR);
    assign bus.init_o        = (state_q == S_INIT);
    assign bus.error_code    = code_q;
    assign bus.error_fifo    = efifo_q;
endmodule

// File: tb/tb_fsm_control_multi.sv
// tb/tb_fsm_control_multi.sv - scoreboard testbench for fsm_control_multi
module tb_fsm_control_multi;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    fsm_control_multi_if #(.NUM_FIFOS(4), .UMBRAL_W(8)) bus ();

    fsm_control_multi #(.NUM_FIFOS(4), .UMBRAL_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [25:0] v;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    bit   done   = 1'b0;

    // {idle, active, error, init_o, error_code, error_fifo, alto_o, bajo_o}
    function automatic logic [25:0] ex(logic i, logic a, logic e, logic n,
                                       logic [1:0] c, logic [3:0] f,
                                       logic [7:0] ta, logic [7:0] tb);
        return {i, a, e, n, c, f, ta, tb};
    endfunction

    task automatic step(input logic r, input logic in, input logic [7:0] a,
                        input logic [7:0] b, input logic [3:0] emp,
                        input logic [3:0] er, input logic [25:0] expv,
                        input string nm);
        exp_t x;
        @(negedge clk);
        reset           = r;
        bus.init        = in;
        bus.umbral_alto = a;
        bus.umbral_bajo = b;
        bus.FIFO_empty  = emp;
        bus.FIFO_error  = er;
        x.v    = expv;
        x.name = nm;
        sb.push_back(x);
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            exp_t x;
            logic [25:0] act;
            x   = sb.pop_front();
            act = {bus.idle, bus.active, bus.error, bus.init_o, bus.error_code,
                   bus.error_fifo, bus.umbral_alto_o, bus.umbral_bajo_o};
            n_cmp++;
            if (act !== x.v) begin
                n_fail++;
                $display("FAIL %s: got i/a/e/n=%b code=%b efifo=%b alto=%0d bajo=%0d, expected i/a/e/n=%b code=%b efifo=%b alto=%0d bajo=%0d",
                         x.name, act[25:22], act[21:20], act[19:16], act[15:8], act[7:0],
                         x.v[25:22], x.v[21:20], x.v[19:16], x.v[15:8], x.v[7:0]);
            end
        end
    end

    initial begin
        repeat (2000) @(posedge clk);
        if (!done) begin
            $display("FAIL watchdog: run still active after 2000 cycles, expected completion");
            n_fail++;
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
            $fatal(1, "timeout");
        end
    end

    initial begin
        reset           = 1'b1;
        bus.init        = 1'b1;
        bus.umbral_alto = '0;
        bus.umbral_bajo = '0;
        bus.FIFO_empty  = 4'hF;
        bus.FIFO_error  = 4'h0;

        step(1, 1, 0,   0,   4'hF, 4'h0, ex(0,0,0,0,2'b00,4'h0,0,0),     "reset_0");
        step(1, 1, 0,   0,   4'hF, 4'h0, ex(0,0,0,0,2'b00,4'h0,0,0),     "reset_1");
        step(0, 1, 0,   0,   4'hF, 4'h0, ex(0,0,0,1,2'b00,4'h0,0,0),     "reset_to_init");
        step(0, 1, 12,  3,   4'hF, 4'h0, ex(0,0,0,1,2'b00,4'h0,12,3),    "init_latch");
        step(0, 0, 12,  3,   4'hF, 4'h0, ex(1,0,0,0,2'b00,4'h0,12,3),    "init_to_idle");
        step(0, 0, 99,  98,  4'hB, 4'h0, ex(0,1,0,0,2'b00,4'h0,12,3),    "idle_to_active");
        step(0, 0, 99,  98,  4'hF, 4'h0, ex(1,0,0,0,2'b00,4'h0,12,3),    "active_to_idle");
        step(0, 0, 99,  98,  4'hB, 4'h0, ex(0,1,0,0,2'b00,4'h0,12,3),    "idle_to_active_2");
        step(0, 0, 99,  98,  4'hF, 4'h4, ex(0,0,1,0,2'b01,4'h4,12,3),    "err_beats_empty");
        step(0, 0, 99,  98,  4'hF, 4'h1, ex(0,0,1,0,2'b01,4'h5,12,3),    "err_sticky");
        step(0, 1, 99,  98,  4'hF, 4'h1, ex(0,0,1,0,2'b01,4'h5,12,3),    "err_init_blocked");
        step(0, 1, 99,  98,  4'hF, 4'h0, ex(0,0,0,1,2'b00,4'h0,12,3),    "err_exit_init");
        step(0, 1, 5,   5,   4'hF, 4'h0, ex(0,0,0,1,2'b00,4'h0,5,5),     "init_equal_thr");
        step(0, 0, 5,   5,   4'hF, 4'h0, ex(0,0,1,0,2'b10,4'h0,5,5),     "cfg_err_equal");
        step(1, 0, 5,   5,   4'hF, 4'h0, ex(0,0,0,0,2'b00,4'h0,0,0),     "reset_in_error");
        step(0, 1, 12,  3,   4'hF, 4'h0, ex(0,0,0,1,2'b00,4'h0,0,0),     "reinit");
        step(0, 1, 12,  3,   4'hF, 4'h0, ex(0,0,0,1,2'b00,4'h0,12,3),    "reinit_latch");
        step(0, 0, 12,  3,   4'hF, 4'h0, ex(1,0,0,0,2'b00,4'h0,12,3),    "reinit_idle");
        step(0, 1, 12,  3,   4'hF, 4'h2, ex(0,0,1,0,2'b01,4'h2,12,3),    "err_beats_init");
        step(1, 0, 12,  3,   4'hF, 4'h0, ex(0,0,0,0,2'b00,4'h0,0,0),     "reset_again");
        step(0, 1, 200, 100, 4'hF, 4'h0, ex(0,0,0,1,2'b00,4'h0,0,0),     "init_wide");
        step(0, 0, 200, 100, 4'hF, 4'h0, ex(1,0,0,0,2'b00,4'h0,200,100), "unsigned_ok");
        step(0, 1, 7,   9,   4'hF, 4'h0, ex(0,0,0,1,2'b00,4'h0,200,100), "idle_to_init_hold");
        step(0, 0, 200, 201, 4'hF, 4'h0, ex(0,0,1,0,2'b10,4'h0,200,201), "cfg_err_bajo_gt");

        begin
            int waited = 0;
            while (sb.size() > 0 && waited < 10) begin
                @(posedge clk);
                waited++;
            end
            #2;
            if (sb.size() > 0) begin
                $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
                n_fail++;
            end
        end
        done = 1'b1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
